muldiv: RTL and testbench

Multi-cycle RV32M multiply/divide unit that sits beside the EX-stage ALU and handles every operation the ALU cannot: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. It accepts a start pulse from EX, raises `busy` so the hazard unit stalls the pipeline, and returns one registered 32-bit result with a single-cycle `done` pulse. A `flush` input lets the pipeline abandon an operation on a branch or exception.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/muldiv_signfix.sv | 31 +++
 rtl/muldiv.sv | 163 ++++++++++++++++
 tb/tb_muldiv.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32M definitions: mdcontrol encoding, muldiv FSM states and iteration count.
// Decoder and muldiv both import this package so the funct3 encoding lives in one place.
package riscv_pkg;

    typedef enum logic [2:0] {
        MD_MUL    = 3'b000,
        MD_MULH   = 3'b001,
        MD_MULHSU = 3'b010,
        MD_MULHU  = 3'b011,
        MD_DIV    = 3'b100,
        MD_DIVU   = 3'b101,
        MD_REM    = 3'b110,
        MD_REMU   = 3'b111
    } mdcontrol_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIN  = 2'd2
    } muldiv_state_e;

    localparam int MULDIV_ITERS = 32;

    function automatic logic md_a_signed(input mdcontrol_e op);
        return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
    endfunction

    function automatic logic md_b_signed(input mdcontrol_e op);
        return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
    endfunction

endpackage

// File: rtl/muldiv_signfix.sv
// Conditional two's-complement negate: either two independent 32-bit lanes
// (operand magnitudes, quotient/remainder fix) or one 64-bit value (product fix).
module muldiv_signfix (
    input  logic        i_wide,
    input  logic [31:0] i_hi,
    input  logic [31:0] i_lo,
    input  logic        i_neg_hi,
    input  logic        i_neg_lo,
    output logic [31:0] o_hi,
    output logic [31:0] o_lo
);

    logic [63:0] w_wide_neg;

    assign w_wide_neg = 64'd0 - {i_hi, i_lo};

    always_comb begin
        o_hi = i_hi;
        o_lo = i_lo;
        if (i_wide) begin
            // i_neg_hi carries the sign of the whole 64-bit value in wide mode
            if (i_neg_hi) begin
                {o_hi, o_lo} = w_wide_neg;
            end
        end else begin
            if (i_neg_hi) o_hi = 32'd0 - i_hi;
            if (i_neg_lo) o_lo = 32'd0 - i_lo;
        end
    end

endmodule

// File: rtl/muldiv.sv
// RV32M multi-cycle multiply/divide unit: shift-add multiply, restoring divide.
// Build option MULDIV_FAST_MUL_EN replaces the iterative multiply with a single-cycle one.
module muldiv
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  mdcontrol,
    input  logic        start,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    localparam logic [5:0] ITER_LAST = 6'(MULDIV_ITERS - 1);

    muldiv_state_e r_state, w_state_next;
    mdcontrol_e    r_op;
    logic [5:0]    r_cnt;
    logic [63:0]   r_acc;
    logic [31:0]   r_opnd;
    logic          r_neg_hi, r_neg_lo;
    logic [31:0]   r_result;

    mdcontrol_e  w_op;
    logic        w_a_neg, w_b_neg;
    logic [31:0] w_a_mag, w_b_mag;
    logic        w_div_zero, w_ovf, w_special, w_fast, w_short, w_accept, w_last;
    logic [31:0] w_special_val, w_fast_val, w_short_val;
    logic [32:0] w_mul_sum;
    logic [63:0] w_mul_next, w_div_next, w_acc_next;
    logic        w_div_ge;
    logic [31:0] w_div_diff;
    logic [31:0] w_res_hi, w_res_lo, w_final;

    assign w_op    = mdcontrol_e'(mdcontrol);
    assign w_a_neg = a[31] & md_a_signed(w_op);
    assign w_b_neg = b[31] & md_b_signed(w_op);

    muldiv_signfix u_opnd_fix (
        .i_wide   (1'b0),
        .i_hi     (a),
        .i_lo     (b),
        .i_neg_hi (w_a_neg),
        .i_neg_lo (w_b_neg),
        .o_hi     (w_a_mag),
        .o_lo     (w_b_mag)
    );

    // Cases resolved at start without iterating; mdcontrol[1] selects REM/REMU
    assign w_div_zero = w_op[2] && (b == 32'd0);
    assign w_ovf      = ((w_op == MD_DIV) || (w_op == MD_REM)) &&
                        (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign w_special  = w_div_zero || w_ovf;

    always_comb begin
        w_special_val = 32'h0;
        if (w_div_zero) w_special_val = w_op[1] ? a : 32'hFFFF_FFFF;
        else            w_special_val = w_op[1] ? 32'h0 : 32'h8000_0000;
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] w_fast_a, w_fast_b, w_fast_prod;

    assign w_fast_a    = {{32{a[31] & md_a_signed(w_op)}}, a};
    assign w_fast_b    = {{32{b[31] & md_b_signed(w_op)}}, b};
    assign w_fast_prod = w_fast_a * w_fast_b;
    assign w_fast      = ~w_op[2];
    assign w_fast_val  = (w_op == MD_MUL) ? w_fast_prod[31:0] : w_fast_prod[63:32];
`else
    assign w_fast      = 1'b0;
    assign w_fast_val  = 32'h0;
`endif

    assign w_short     = w_special || w_fast;
    assign w_short_val = w_special ? w_special_val : w_fast_val;
    assign w_accept    = start && !flush && (r_state != MD_CALC);

    // Multiply: acc = {partial product, remaining multiplier bits}
    assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
    assign w_mul_next = {w_mul_sum, r_acc[31:1]};

    // Divide: acc = {partial remainder, dividend bits / quotient bits}
    assign w_div_ge   = r_acc[63:31] >= {1'b0, r_opnd};
    assign w_div_diff = r_acc[62:31] - r_opnd;
    assign w_div_next = w_div_ge ? {w_div_diff, r_acc[30:0], 1'b1}
                                 : {r_acc[62:0], 1'b0};

    assign w_acc_next = r_op[2] ? w_div_next : w_mul_next;
    assign w_last     = (r_cnt == ITER_LAST);

    muldiv_signfix u_res_fix (
        .i_wide   (~r_op[2]),
        .i_hi     (w_acc_next[63:32]),
        .i_lo     (w_acc_next[31:0]),
        .i_neg_hi (r_neg_hi),
        .i_neg_lo (r_neg_lo),
        .o_hi     (w_res_hi),
        .o_lo     (w_res_lo)
    );

    assign w_final = ((r_op == MD_MUL) || (r_op == MD_DIV) || (r_op == MD_DIVU)) ? w_res_lo
                                                                                  : w_res_hi;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            MD_IDLE, MD_FIN: begin
                if (start) w_state_next = w_short ? MD_FIN : MD_CALC;
                else       w_state_next = MD_IDLE;
            end
            MD_CALC: begin
                if (w_last) w_state_next = MD_FIN;
            end
            default: w_state_next = MD_IDLE;
        endcase
        if (flush) w_state_next = MD_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= MD_IDLE;
        else       r_state <= w_state_next;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op     <= MD_MUL;
            r_cnt    <= 6'd0;
            r_acc    <= 64'd0;
            r_opnd   <= 32'd0;
            r_neg_hi <= 1'b0;
            r_neg_lo <= 1'b0;
            r_result <= 32'd0;
        end else if (w_accept) begin
            r_op  <= w_op;
            r_cnt <= 6'd0;
            if (w_op[2]) begin
                r_acc    <= {32'd0, w_a_mag};
                r_opnd   <= w_b_mag;
                r_neg_hi <= w_a_neg;
                r_neg_lo <= w_a_neg ^ w_b_neg;
            end else begin
                r_acc    <= {32'd0, w_b_mag};
                r_opnd   <= w_a_mag;
                r_neg_hi <= w_a_neg ^ w_b_neg;
                r_neg_lo <= 1'b0;
            end
            if (w_short) r_result <= w_short_val;
        end else if ((r_state == MD_CALC) && !flush) begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + 6'd1;
            if (w_last) r_result <= w_final;
        end
    end

    assign busy   = (r_state == MD_CALC);
    assign done   = (r_state == MD_FIN);
    assign result = r_result;

endmodule

// File: tb/tb_muldiv.sv
// Self-checking bench for muldiv: vector table, random ops against a reference model,
// plus flush, back-to-back and mid-operation reset sequences.
module tb_muldiv;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] a_i = 32'd0, b_i = 32'd0;
    logic [2:0]  mdc = 3'd0;
    logic        start = 1'b0, flush = 1'b0;
    logic        busy, done;
    logic [31:0] result;

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];
    logic [31:0] last_exp = 32'd0;

`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    muldiv dut (
        .clk       (clk),
        .reset     (reset),
        .a         (a_i),
        .b         (b_i),
        .mdcontrol (mdc),
        .start     (start),
        .flush     (flush),
        .busy      (busy),
        .done      (done),
        .result    (result)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] model_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ua, ub, sa, sb, p;
        int ia, ib;
        logic ovf;
        ua = {32'd0, a}; ub = {32'd0, b};
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ia = a; ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (!op[2]) return MUL_LAT;
        if (b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 33;
    endfunction

    // Drive a start for one cycle; returns at the negedge of cycle 1
    task automatic issue(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] exp);
        @(negedge clk);
        mdc = op; a_i = ia; b_i = ib; start = 1'b1;
        exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called at the negedge of cycle 1; returns at the negedge where done is seen
    task automatic wait_done(input string nm, input int lat);
        int cyc, busy_cnt;
        bit got;
        logic [31:0] e;
        cyc = 1; busy_cnt = 0; got = 0;
        while (!got && cyc <= 100) begin
            if (done) begin
                got = 1;
                e = exp_q.pop_front();
                last_exp = e;
                check({nm, " result"}, result, e);
                check({nm, " latency"}, cyc, lat);
                check({nm, " busy_in_done"}, {31'd0, busy}, 32'd0);
            end else begin
                if (busy) busy_cnt++;
                @(negedge clk);
                cyc++;
            end
        end
        if (!got) begin
            checks++;
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles, expected result %h", nm, cyc, exp_q[0]);
            void'(exp_q.pop_front());
        end
        check({nm, " busy_cycles"}, busy_cnt, lat - 1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] ia, input logic [31:0] ib,
                         input logic [31:0] exp, input int lat, input string nm);
        issue(op, ia, ib, exp);
        wait_done(nm, lat);
        @(negedge clk);
        check({nm, " done_pulse"}, {31'd0, done}, 32'd0);
    endtask

    vec_t vecs[13];

    initial begin
        int done_cnt;
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_7_m3"};
        vecs[1]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, MUL_LAT, "mulhu_max"};
        vecs[2]  = '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, MUL_LAT, "mulh_m1"};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MUL_LAT, "mulhsu_m1"};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33,      "div_m7_2"};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33,      "rem_m7_2"};
        vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33,      "divu_100_7"};
        vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33,      "remu_100_7"};
        vecs[8]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1,       "divu_by0"};
        vecs[9]  = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,       "rem_ovf"};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,       "div_ovf"};
        vecs[11] = '{3'd7, 32'd5,          32'd0,         32'd5,         1,       "remu_by0"};
        vecs[12] = '{3'd4, 32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 1,       "div_by0"};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        for (int i = 0; i < 13; i++)
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0: rb = 32'($urandom_range(1, 300));
                1: rb = 32'd0;
                2: rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            if (i == 0) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; rop = 3'd4; end
            do_op(rop, ra, rb, model_md(rop, ra, rb), model_lat(rop, ra, rb), $sformatf("rand%0d", i));
        end

        // Flush in cycle 10 of a divide, then start+flush together in IDLE
        @(negedge clk);
        mdc = 3'd4; a_i = 32'd1000; b_i = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 10; c++) @(negedge clk);
        check("flush busy_c10", {31'd0, busy}, 32'd1);
        flush = 1'b1;
        @(negedge clk);
        check("flush idle_c11", {31'd0, busy}, 32'd0);
        check("flush nodone_c11", {31'd0, done}, 32'd0);
        mdc = 3'd5; a_i = 32'd5; b_i = 32'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("flush start_dropped busy", {31'd0, busy}, 32'd0);
        done_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        check("flush done_count", done_cnt, 0);
        check("flush result_held", result, last_exp);

        // Start in the FIN cycle launches the next op with no idle gap
        issue(3'd5, 32'd100, 32'd7, 32'd14);
        wait_done("b2b first", 33);
        mdc = 3'd7; a_i = 32'd100; b_i = 32'd7; start = 1'b1;
        exp_q.push_back(32'd2);
        @(negedge clk);
        start = 1'b0;
        check("b2b busy_no_gap", {31'd0, busy}, 32'd1);
        wait_done("b2b second", 33);
        @(negedge clk);
        check("b2b done_pulse", {31'd0, done}, 32'd0);

        // Reset at cycle 20 of an in-flight operation
        @(negedge clk);
`ifdef MULDIV_FAST_MUL_EN
        mdc = 3'd4; a_i = 32'd1000; b_i = 32'd3;
`else
        mdc = 3'd0; a_i = 32'd7; b_i = 32'hFFFF_FFFD;
`endif
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c < 20; c++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid busy", {31'd0, busy}, 32'd0);
        check("rst_mid done", {31'd0, done}, 32'd0);
        check("rst_mid result", result, 32'd0);
        reset = 1'b0;
        do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, MUL_LAT, "mul_after_rst");

        check("scoreboard empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
